// File: rtl/peak_tone_cfg_pkg.sv
// peak_tone_cfg_pkg
//   Shared types and constants for the peak-to-tone configuration block:
//   FSM state type, DDS phase-increment and amplitude word widths, and the
//   FFT length from which the default phase increment per bin is derived.
package peak_tone_cfg_pkg;

  localparam int unsigned PINC_W    = 32;
  localparam int unsigned AMP_OUT_W = 16;
  localparam int unsigned FFT_LEN   = 128;

  // One FFT bin spans 2^PINC_W / FFT_LEN of the DDS phase circle.
  localparam logic [PINC_W-1:0] PINC_PER_BIN_DFLT =
    PINC_W'((64'd1 << PINC_W) / 64'(FFT_LEN));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/peak_tone_cfg_seq_shift_mult.sv
// seq_shift_mult
//   Start/done serial multiplier, LSB-first shift-add, A_W x P_W truncated
//   to P_W bits (mod 2^P_W).
//   Ports:
//     clk, rst  clock, synchronous active-high reset
//     start     load operands (takes precedence over a running product)
//     a         multiplier (A_W bits), consumed LSB first
//     b         multiplicand (P_W bits)
//     done      high for one cycle once all A_W partial products are summed
//     product   running/final product, stable while done is high
module seq_shift_mult #(
  parameter int unsigned A_W = 8,
  parameter int unsigned P_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [A_W-1:0] a,
  input  logic [P_W-1:0] b,
  output logic           done,
  output logic [P_W-1:0] product
);

  localparam int unsigned CW = $clog2(A_W + 1);

  logic [A_W-1:0] a_sh;
  logic [P_W-1:0] b_sh;
  logic [CW-1:0]  steps;
  logic           active;

  // The first partial product is summed on the start edge itself, so the
  // remaining A_W-1 steps finish in time for done to sit in the A_W-th
  // cycle after start.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      steps   <= '0;
      active  <= 1'b0;
      product <= '0;
    end else if (start) begin
      product <= a[0] ? b : '0;
      a_sh    <= a >> 1;
      b_sh    <= b << 1;
      steps   <= CW'(1);
      active  <= 1'b1;
    end else if (active) begin
      if (steps == CW'(A_W)) begin
        active <= 1'b0;
      end else begin
        if (a_sh[0]) begin
          product <= product + b_sh;
        end
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh << 1;
        steps <= steps + CW'(1);
      end
    end
  end

  always_comb begin
    done = active && (steps == CW'(A_W));
  end

endmodule

// File: rtl/peak_tone_cfg.sv
// peak_tone_cfg
//   Turns peak-search results (bin index + amplitude) into a DDS phase
//   increment and an amplitude scale word. Amplitude is averaged over
//   2^AVG_LOG2 consecutive frames of the same bin; DC frames are dropped;
//   a result identical to the last one delivered is not re-sent.
//   Ports:
//     clk, rst               clock, synchronous active-high reset
//     s_axis_tvalid/tready   peak result handshake (ready only when idle)
//     s_axis_taddr           peak bin index
//     s_axis_tdata           peak amplitude, unsigned
//     m_axis_config_tvalid   DDS config valid (registered)
//     m_axis_config_tready   DDS accepts config
//     m_axis_config_tdata    phase increment
//     amp_word               amplitude scale, valid with config tvalid
//     busy                   block is not idle
module peak_tone_cfg
  import peak_tone_cfg_pkg::*;
#(
  parameter int unsigned        ADDR_WIDTH   = 8,
  parameter int unsigned        AMP_WIDTH    = 25,
  parameter logic [PINC_W-1:0]  PINC_PER_BIN = PINC_PER_BIN_DFLT,
  parameter int unsigned        AVG_LOG2     = 2,
  parameter logic [15:0]        AMP_GAIN     = 16'd1,
  parameter int unsigned        AMP_SHIFT    = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [ADDR_WIDTH-1:0] s_axis_taddr,
  input  logic [AMP_WIDTH-1:0]  s_axis_tdata,
  output logic                  m_axis_config_tvalid,
  input  logic                  m_axis_config_tready,
  output logic [PINC_W-1:0]     m_axis_config_tdata,
  output logic [AMP_OUT_W-1:0]  amp_word,
  output logic                  busy
);

  localparam int unsigned WIN    = 1 << AVG_LOG2;
  localparam int unsigned CNT_W  = AVG_LOG2 + 1;
  localparam int unsigned ACC_W  = AMP_WIDTH + AVG_LOG2;
  localparam int unsigned PROD_W = AMP_WIDTH + 16;

  state_t                 state;
  logic [ACC_W-1:0]       acc;
  logic [ACC_W-1:0]       acc_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nxt;
  logic [ADDR_WIDTH-1:0]  cur_bin;
  logic [AMP_WIDTH-1:0]   avg;
  logic                   have_last;
  logic [PINC_W-1:0]      last_pinc;
  logic [AMP_OUT_W-1:0]   last_amp;

  logic                   accept;
  logic                   is_dc;
  logic                   restart;
  logic                   win_done;
  logic                   mult_done;
  logic [PINC_W-1:0]      pinc;
  logic [PROD_W-1:0]      scaled;
  logic [AMP_OUT_W-1:0]   amp_sat;
  logic                   suppress;

  seq_shift_mult #(
    .A_W (ADDR_WIDTH),
    .P_W (PINC_W)
  ) u_mult (
    .clk     (clk),
    .rst     (rst),
    .start   (win_done),
    .a       (s_axis_taddr),
    .b       (PINC_PER_BIN),
    .done    (mult_done),
    .product (pinc)
  );

  always_comb begin
    s_axis_tready = (state == IDLE);
    busy          = (state != IDLE);
    accept        = (state == IDLE) && s_axis_tvalid;
    is_dc         = (s_axis_taddr == '0);
    restart       = (s_axis_taddr != cur_bin) || (cnt == '0);
    acc_nxt       = restart ? ACC_W'(s_axis_tdata) : acc + ACC_W'(s_axis_tdata);
    cnt_nxt       = restart ? CNT_W'(1) : cnt + CNT_W'(1);
    win_done      = accept && !is_dc && (cnt_nxt == CNT_W'(WIN));
  end

  // avg is stable for the whole MUL phase, so the scaled/saturated word is
  // settled by the time the multiplier reports done.
  always_comb begin
    scaled   = (PROD_W'(avg) * PROD_W'(AMP_GAIN)) >> AMP_SHIFT;
    amp_sat  = (scaled > PROD_W'(16'hFFFF)) ? '1 : scaled[AMP_OUT_W-1:0];
    suppress = have_last && (pinc == last_pinc) && (amp_sat == last_amp);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      acc                  <= '0;
      cnt                  <= '0;
      cur_bin              <= '0;
      avg                  <= '0;
      have_last            <= 1'b0;
      last_pinc            <= '0;
      last_amp             <= '0;
      m_axis_config_tvalid <= 1'b0;
      m_axis_config_tdata  <= '0;
      amp_word             <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_dc) begin
              acc <= '0;
              cnt <= '0;
            end else if (win_done) begin
              // The window average is captured from the completing sum
              // directly, letting acc/cnt clear on the same edge.
              cur_bin <= s_axis_taddr;
              avg     <= AMP_WIDTH'(acc_nxt >> AVG_LOG2);
              acc     <= '0;
              cnt     <= '0;
              state   <= MUL;
            end else begin
              cur_bin <= s_axis_taddr;
              acc     <= acc_nxt;
              cnt     <= cnt_nxt;
            end
          end
        end

        MUL: begin
          if (mult_done) begin
            if (suppress) begin
              state <= IDLE;
            end else begin
              m_axis_config_tdata  <= pinc;
              amp_word             <= amp_sat;
              m_axis_config_tvalid <= 1'b1;
              state                <= OUT;
            end
          end
        end

        OUT: begin
          if (m_axis_config_tready) begin
            m_axis_config_tvalid <= 1'b0;
            last_pinc            <= m_axis_config_tdata;
            last_amp             <= amp_word;
            have_last            <= 1'b1;
            state                <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_peak_tone_cfg.sv
// tb_peak_tone_cfg
//   Directed and randomized frames into two instances of peak_tone_cfg
//   (default gain, and gain 2), checked against a window-average model.
module tb_peak_tone_cfg;

  logic        clk = 1'b0;
  logic        rst;
  logic        s0_v, s1_v, s0_r, s1_r;
  logic [7:0]  s0_a, s1_a;
  logic [24:0] s0_d, s1_d;
  logic        c0_v, c1_v, c0_r, c1_r;
  logic [31:0] c0_d, c1_d;
  logic [15:0] a0, a1;
  logic        b0, b1;

  int unsigned passed = 0;
  int unsigned total  = 0;

  peak_tone_cfg dut0 (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s0_v), .s_axis_tready(s0_r),
    .s_axis_taddr(s0_a), .s_axis_tdata(s0_d),
    .m_axis_config_tvalid(c0_v), .m_axis_config_tready(c0_r),
    .m_axis_config_tdata(c0_d), .amp_word(a0), .busy(b0)
  );

  peak_tone_cfg #(.AMP_GAIN(16'd2)) dut1 (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s1_v), .s_axis_tready(s1_r),
    .s_axis_taddr(s1_a), .s_axis_tdata(s1_d),
    .m_axis_config_tvalid(c1_v), .m_axis_config_tready(c1_r),
    .m_axis_config_tdata(c1_d), .amp_word(a1), .busy(b1)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- reference model ----------------
  localparam longint unsigned PINC = 64'h1_0000_0000 / 128;
  int unsigned     m_n   [2];
  int unsigned     m_bin [2];
  longint unsigned m_sum [2];
  bit              m_have[2];
  longint unsigned m_lp  [2];
  longint unsigned m_la  [2];
  longint unsigned e_pinc, e_amp;

  function automatic void model_reset(input int w);
    m_n[w] = 0; m_have[w] = 0; m_bin[w] = 0; m_sum[w] = 0;
  endfunction

  // 0: no window completed, 1: window completed but repeats last output,
  // 2: new config expected (e_pinc/e_amp).
  function automatic int model_frame(input int w, input int unsigned bin,
                                     input longint unsigned amp);
    longint unsigned gain = (w == 1) ? 2 : 1;
    if (bin == 0) begin
      m_n[w] = 0;
      return 0;
    end
    if (m_n[w] == 0 || bin != m_bin[w]) begin
      m_bin[w] = bin; m_sum[w] = amp; m_n[w] = 1;
    end else begin
      m_sum[w] += amp; m_n[w]++;
    end
    if (m_n[w] < 4) return 0;
    m_n[w] = 0;
    e_pinc = (longint'(bin) * PINC) % 64'h1_0000_0000;
    e_amp  = ((m_sum[w] / 4) * gain) / 512;
    if (e_amp > 65535) e_amp = 65535;
    if (m_have[w] && e_pinc == m_lp[w] && e_amp == m_la[w]) return 1;
    m_have[w] = 1; m_lp[w] = e_pinc; m_la[w] = e_amp;
    return 2;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
  endtask

  function automatic logic sready(input int w);  return w ? s1_r : s0_r; endfunction
  function automatic logic cvalid(input int w);  return w ? c1_v : c0_v; endfunction
  function automatic logic isbusy(input int w);  return w ? b1 : b0; endfunction
  function automatic logic [31:0] cdata(input int w); return w ? c1_d : c0_d; endfunction
  function automatic logic [15:0] ampw(input int w);  return w ? a1 : a0; endfunction

  task automatic drive(input int w, input logic v, input logic [7:0] a, input logic [24:0] d);
    if (w == 1) begin s1_v = v; s1_a = a; s1_d = d; end
    else        begin s0_v = v; s0_a = a; s0_d = d; end
  endtask

  // Returns at the falling edge just after the handshake edge (cycle 1).
  task automatic send(input int w, input logic [7:0] bin, input logic [24:0] amp);
    int n = 0;
    while (!sready(w) && n < 50) begin @(negedge clk); n++; end
    check("send_ready", sready(w), 1'b1);
    drive(w, 1'b1, bin, amp);
    @(posedge clk);
    @(negedge clk);
    drive(w, 1'b0, '0, '0);
  endtask

  task automatic expect_emit(input int w);
    int cyc = 1;
    while (!cvalid(w) && cyc < 40) begin @(negedge clk); cyc++; end
    check("emit_latency", cyc, 9);
    check("emit_tdata", cdata(w), e_pinc);
    check("emit_amp", ampw(w), e_amp);
    check("emit_sready_low", sready(w), 1'b0);
    @(negedge clk);
    check("post_valid_low", cvalid(w), 1'b0);
    check("post_sready", sready(w), 1'b1);
  endtask

  task automatic settle(input int w, input int code);
    bit saw = 0;
    if (code == 0) begin
      check("idle_ready", sready(w), 1'b1);
      check("idle_busy", isbusy(w), 1'b0);
    end else if (code == 1) begin
      check("supp_busy", isbusy(w), 1'b1);
      for (int c = 1; c < 9; c++) begin
        if (cvalid(w) !== 1'b0) saw = 1;
        @(negedge clk);
      end
      check("supp_novalid", saw, 1'b0);
      check("supp_ready", sready(w), 1'b1);
    end else begin
      expect_emit(w);
    end
  endtask

  task automatic frame(input int w, input logic [7:0] bin, input logic [24:0] amp);
    int code;
    send(w, bin, amp);
    code = model_frame(w, bin, amp);
    settle(w, code);
  endtask

  task automatic check_reset(input int w);
    check("rst_sready", sready(w), 1'b1);
    check("rst_cvalid", cvalid(w), 1'b0);
    check("rst_tdata", cdata(w), 32'd0);
    check("rst_amp", ampw(w), 16'd0);
    check("rst_busy", isbusy(w), 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          code;
    int          cyc;
    bit          stable, rdy_low;
    logic [31:0] hold_d;
    logic [15:0] hold_a;
    logic [7:0]  rb;
    logic [24:0] ra;

    rst = 1'b1;
    drive(0, 1'b0, '0, '0);
    drive(1, 1'b0, '0, '0);
    c0_r = 1'b1; c1_r = 1'b1;
    model_reset(0); model_reset(1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int w = 0; w < 2; w++) check_reset(w);

    // emit, then suppress identical window
    repeat (4) frame(0, 8'd5, 25'h010000);
    repeat (4) frame(0, 8'd5, 25'h010000);
    // bin change while suppression armed
    repeat (4) frame(0, 8'd6, 25'h010000);
    // bin change inside a window
    frame(0, 8'd5, 25'h010000); frame(0, 8'd5, 25'h010000);
    repeat (4) frame(0, 8'd7, 25'h010000);
    // DC frame mid-window restarts accumulation
    frame(0, 8'd7, 25'h010000); frame(0, 8'd7, 25'h010000);
    frame(0, 8'd0, 25'h010000);
    repeat (3) frame(0, 8'd7, 25'h010000);

    // saturation on the gain-2 instance
    repeat (4) frame(1, 8'd3, 25'h1FFFFFF);

    // backpressure on the config port with an upstream frame waiting
    c0_r = 1'b0;
    repeat (3) frame(0, 8'd9, 25'h030000);
    send(0, 8'd9, 25'h030000);
    code = model_frame(0, 9, 25'h030000);
    check("bp_model_emits", code, 2);
    cyc = 1;
    while (!c0_v && cyc < 40) begin @(negedge clk); cyc++; end
    check("bp_latency", cyc, 9);
    hold_d = c0_d; hold_a = a0;
    drive(0, 1'b1, 8'd9, 25'h040000);
    stable = 1; rdy_low = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (c0_v !== 1'b1 || c0_d !== hold_d || a0 !== hold_a) stable = 0;
      if (s0_r !== 1'b0) rdy_low = 0;
    end
    check("bp_stable", stable, 1'b1);
    check("bp_sready_low", rdy_low, 1'b1);
    check("bp_tdata", hold_d, e_pinc);
    check("bp_amp", hold_a, e_amp);
    c0_r = 1'b1;
    @(negedge clk);
    check("bp_release_valid", c0_v, 1'b0);
    check("bp_stalled_ready", s0_r, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, '0, '0);
    code = model_frame(0, 9, 25'h040000);
    settle(0, code);
    repeat (3) frame(0, 8'd9, 25'h040000);

    // reset during MUL clears the suppression history
    repeat (4) frame(0, 8'd11, 25'h010000);
    repeat (3) frame(0, 8'd11, 25'h010000);
    send(0, 8'd11, 25'h010000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset(0); model_reset(1);
    check_reset(0);
    repeat (4) frame(0, 8'd11, 25'h010000);

    // randomized frames, mostly two bins so windows complete and repeat
    for (int i = 0; i < 96; i++) begin
      int unsigned r = $urandom_range(0, 15);
      rb = (r == 0) ? 8'd0 : (r < 11) ? 8'd2 : 8'd3;
      ra = ($urandom_range(0, 1) == 1) ? 25'h010000 : 25'($urandom);
      frame(0, rb, ra);
    end
    for (int i = 0; i < 8; i++) begin
      frame(1, 8'($urandom_range(1, 127)), 25'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
